// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants for the raster timing generator and its consumers.
//   timing_t      : one complete set of porch/sync/active values plus sync
//                   polarities for a video mode
//   VGA_640X480   : 640x480@60, 25.175 MHz pixel clock, negative syncs
//   SVGA_800X600  : 800x600@60, 40 MHz pixel clock, positive syncs
//   XGA_1024X768  : 1024x768@60, 65 MHz pixel clock, negative syncs
//   total_width() : bits needed to count 0..total-1, used to validate the
//                   counter width chosen at elaboration
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    typedef struct packed {
        int unsigned h_sync;
        int unsigned h_back;
        int unsigned h_active;
        int unsigned h_front;
        int unsigned v_sync;
        int unsigned v_back;
        int unsigned v_active;
        int unsigned v_front;
        logic        h_pol;
        logic        v_pol;
    } timing_t;

    localparam timing_t VGA_640X480 = '{
        h_sync: 96,  h_back: 48,  h_active: 640,  h_front: 16,
        v_sync: 2,   v_back: 33,  v_active: 480,  v_front: 10,
        h_pol: 1'b0, v_pol: 1'b0
    };

    localparam timing_t SVGA_800X600 = '{
        h_sync: 128, h_back: 88,  h_active: 800,  h_front: 40,
        v_sync: 4,   v_back: 23,  v_active: 600,  v_front: 1,
        h_pol: 1'b1, v_pol: 1'b1
    };

    localparam timing_t XGA_1024X768 = '{
        h_sync: 136, h_back: 160, h_active: 1024, h_front: 24,
        v_sync: 6,   v_back: 29,  v_active: 768,  v_front: 3,
        h_pol: 1'b0, v_pol: 1'b0
    };

    // Number of bits required to hold every value 0..total-1.
    function automatic int unsigned total_width(input int unsigned total);
        return (total <= 1) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: a counter that runs 0..TOTAL-1 and wraps, plus the
// combinational decode of where the current count sits in the line/frame.
// Used once for the horizontal axis (pixels) and once for the vertical
// axis (lines).
// Ports:
//   clk       : pixel clock
//   rst       : synchronous active-high reset, forces count to 0
//   en        : advance enable
//   in_sync   : count is inside the sync pulse [0, SYNC-1]
//   in_active : count is inside the visible region
//   coord     : zero-based offset into the visible region (0 outside it)
//   wrap      : count is at TOTAL-1 and en is high, i.e. it wraps this edge
// ---------------------------------------------------------------------------
module vga_axis_counter #(
    parameter int SYNC   = 96,
    parameter int BACK   = 48,
    parameter int ACTIVE = 640,
    parameter int FRONT  = 16,
    parameter int CW     = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          in_sync,
    output logic          in_active,
    output logic [CW-1:0] coord,
    output logic          wrap
);

    localparam int TOTAL     = SYNC + BACK + ACTIVE + FRONT;
    localparam int ACT_START = SYNC + BACK;
    localparam int ACT_END   = ACT_START + ACTIVE - 1;

    localparam logic [CW-1:0] LAST_C      = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_LAST_C = CW'(SYNC - 1);
    localparam logic [CW-1:0] ACT_START_C = CW'(ACT_START);
    localparam logic [CW-1:0] ACT_END_C   = CW'(ACT_END);

    logic [CW-1:0] count;

    // Wrap is qualified by en so that downstream users (the next axis, the
    // frame counter) can treat it directly as a "step now" strobe.
    always_comb begin
        wrap      = en && (count == LAST_C);
        in_sync   = (count <= SYNC_LAST_C);
        in_active = (count >= ACT_START_C) && (count <= ACT_END_C);
        coord     = in_active ? (count - ACT_START_C) : '0;
    end

    // Free-running position counter; holds while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : (count + CW'(1));
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Raster timing generator for the display pipeline. Two axis counters
// track the current (hc, vc) position; this level decodes that position
// into registered sync, data-enable, coordinate and marker outputs, so all
// outputs lag the counters by one pixel clock.
// Ports:
//   vga_clk   : pixel clock (single domain)
//   rst       : synchronous active-high reset
//   en        : pixel enable; low freezes counters and every output
//   hsync     : H_POL during the horizontal sync pulse, ~H_POL otherwise
//   vsync     : V_POL during the vertical sync pulse, ~V_POL otherwise
//   de        : high on visible pixels
//   x, y      : zero-based visible coordinates, 0 when de is low
//   sof       : high on pixel (0,0)
//   eol       : high on the last visible pixel of each line
//   frame_cnt : completed-frame counter, wraps
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_SYNC   = 96,
    parameter int   H_BACK   = 48,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FRONT  = 16,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 33,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FRONT  = 10,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0,
    parameter int   CW       = 12,
    parameter int   FCW      = 16
) (
    input  logic           vga_clk,
    input  logic           rst,
    input  logic           en,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [CW-1:0]  x,
    output logic [CW-1:0]  y,
    output logic           sof,
    output logic           eol,
    output logic [FCW-1:0] frame_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [CW-1:0] X_LAST_C = CW'(H_ACTIVE - 1);

    // Refuse to elaborate with counters too narrow for the chosen mode.
    if (CW < int'(total_width(H_TOTAL)) || CW < int'(total_width(V_TOTAL))) begin : g_cw_check
        $error("vga_timing_gen: CW is too narrow for H_TOTAL/V_TOTAL");
    end

    logic          h_in_sync;
    logic          h_in_active;
    logic [CW-1:0] h_coord;
    logic          h_wrap;
    logic          v_in_sync;
    logic          v_in_active;
    logic [CW-1:0] v_coord;
    logic          v_wrap;

    logic          de_next;
    logic [CW-1:0] x_next;
    logic [CW-1:0] y_next;
    logic          sof_next;
    logic          eol_next;

    vga_axis_counter #(
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .CW     (CW)
    ) u_h_axis (
        .clk       (vga_clk),
        .rst       (rst),
        .en        (en),
        .in_sync   (h_in_sync),
        .in_active (h_in_active),
        .coord     (h_coord),
        .wrap      (h_wrap)
    );

    // The line counter steps once per completed line; h_wrap already
    // carries en, the explicit AND keeps that dependency obvious.
    vga_axis_counter #(
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .CW     (CW)
    ) u_v_axis (
        .clk       (vga_clk),
        .rst       (rst),
        .en        (en && h_wrap),
        .in_sync   (v_in_sync),
        .in_active (v_in_active),
        .coord     (v_coord),
        .wrap      (v_wrap)
    );

    // Visible-pixel decode of the current position. Coordinates are forced
    // to zero outside the visible window so consumers never see stale
    // horizontal offsets during vertical blanking.
    always_comb begin
        de_next  = h_in_active && v_in_active;
        x_next   = de_next ? h_coord : '0;
        y_next   = de_next ? v_coord : '0;
        sof_next = de_next && (x_next == '0) && (y_next == '0);
        eol_next = de_next && (x_next == X_LAST_C);
    end

    // Output registers and frame counter. Everything holds while en is low,
    // so a marker pulse that is up when the stall begins stays up for it.
    // v_wrap is only high when both axes wrap on this enabled edge.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            hsync     <= ~H_POL;
            vsync     <= ~V_POL;
            de        <= 1'b0;
            x         <= '0;
            y         <= '0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            frame_cnt <= '0;
        end else if (en) begin
            hsync <= h_in_sync ? H_POL : ~H_POL;
            vsync <= v_in_sync ? V_POL : ~V_POL;
            de    <= de_next;
            x     <= x_next;
            y     <= y_next;
            sof   <= sof_next;
            eol   <= eol_next;
            if (v_wrap) begin
                frame_cnt <= frame_cnt + FCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Drives two instances from one clock and one rst/en pair:
//   dut_def   : default 640x480 timing, checked over the first 36 lines
//   dut_small : H 4/2/8/2, V 2/1/4/1, positive syncs, 2-bit frame counter,
//               checked every cycle through frames, a stall and a reset
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic en;

    always #5 clk = ~clk;

    logic        d_hsync, d_vsync, d_de, d_sof, d_eol;
    logic [11:0] d_x, d_y;
    logic [15:0] d_frame_cnt;

    logic        s_hsync, s_vsync, s_de, s_sof, s_eol;
    logic [7:0]  s_x, s_y;
    logic [1:0]  s_frame_cnt;

    int checks = 0;
    int errors = 0;

    vga_timing_gen dut_def (
        .vga_clk   (clk),
        .rst       (rst),
        .en        (en),
        .hsync     (d_hsync),
        .vsync     (d_vsync),
        .de        (d_de),
        .x         (d_x),
        .y         (d_y),
        .sof       (d_sof),
        .eol       (d_eol),
        .frame_cnt (d_frame_cnt)
    );

    vga_timing_gen #(
        .H_SYNC (4), .H_BACK (2), .H_ACTIVE (8), .H_FRONT (2),
        .V_SYNC (2), .V_BACK (1), .V_ACTIVE (4), .V_FRONT (1),
        .H_POL  (1'b1), .V_POL (1'b1),
        .CW     (8), .FCW (2)
    ) dut_small (
        .vga_clk   (clk),
        .rst       (rst),
        .en        (en),
        .hsync     (s_hsync),
        .vsync     (s_vsync),
        .de        (s_de),
        .x         (s_x),
        .y         (s_y),
        .sof       (s_sof),
        .eol       (s_eol),
        .frame_cnt (s_frame_cnt)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Drive rst/en, then advance one clock and settle 1 time unit past it.
    task automatic applyStimulus(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge clk);
        #1;
    endtask

    // Expected small-instance outputs after p enabled edges since reset.
    // Line is 16 pixels: sync 0..3, active 6..13. Frame is 8 lines:
    // sync 0..1, active 3..6. Outputs show the position before the last
    // edge; the frame counter steps on every 128th edge.
    task automatic checkSmall(input int p);
        int q, hc, vc;
        logic e_hs, e_vs, e_de, e_sof, e_eol;
        int e_x, e_y, e_fc;
        if (p == 0) begin
            e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0;
            e_x = 0; e_y = 0; e_sof = 1'b0; e_eol = 1'b0; e_fc = 0;
        end else begin
            q    = p - 1;
            hc   = q % 16;
            vc   = (q / 16) % 8;
            e_hs = (hc < 4);
            e_vs = (vc < 2);
            e_de = (hc >= 6) && (hc <= 13) && (vc >= 3) && (vc <= 6);
            e_x  = e_de ? hc - 6 : 0;
            e_y  = e_de ? vc - 3 : 0;
            e_sof = e_de && (e_x == 0) && (e_y == 0);
            e_eol = e_de && (e_x == 7);
            e_fc = (p / 128) % 4;
        end
        checkOutput("s_hsync", 32'(s_hsync), 32'(e_hs));
        checkOutput("s_vsync", 32'(s_vsync), 32'(e_vs));
        checkOutput("s_de", 32'(s_de), 32'(e_de));
        checkOutput("s_x", 32'(s_x), 32'(e_x));
        checkOutput("s_y", 32'(s_y), 32'(e_y));
        checkOutput("s_sof", 32'(s_sof), 32'(e_sof));
        checkOutput("s_eol", 32'(s_eol), 32'(e_eol));
        checkOutput("s_frame_cnt", 32'(s_frame_cnt), 32'(e_fc));
    endtask

    initial begin
        int hs_low_line0, hs_low_all, vs_low;
        int de_first, de_last, de_cnt;
        int sof_cnt, sof_n, sof_x, sof_y;
        int eol_cnt, eol_n, eol_x;
        int p, found, k, len, sof_after;
        logic [7:0] hold_x;

        hs_low_line0 = 0; hs_low_all = 0; vs_low = 0;
        de_first = -1; de_last = -1; de_cnt = 0;
        sof_cnt = 0; sof_n = -1; sof_x = -1; sof_y = -1;
        eol_cnt = 0; eol_n = -1; eol_x = -1;

        // Reset state of both instances, en high to show reset wins.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("def_rst_hsync", 32'(d_hsync), 32'd1);
        checkOutput("def_rst_vsync", 32'(d_vsync), 32'd1);
        checkOutput("def_rst_de", 32'(d_de), 32'd0);
        checkOutput("def_rst_x", 32'(d_x), 32'd0);
        checkOutput("def_rst_frame_cnt", 32'(d_frame_cnt), 32'd0);
        checkSmall(0);

        // Default timing: first 36 lines plus a little, index n = edges
        // since release, showing pixel index n-1.
        for (int n = 1; n <= 28900; n++) begin
            applyStimulus(1'b0, 1'b1);
            if (n == 1) begin
                checkOutput("def_hsync_first", 32'(d_hsync), 32'd0);
                checkOutput("def_vsync_first", 32'(d_vsync), 32'd0);
            end
            if (n <= 800 && !d_hsync) hs_low_line0++;
            if (n <= 28800 && !d_hsync) hs_low_all++;
            if (n <= 28800 && !d_vsync) vs_low++;
            if (d_de) begin
                if (de_first < 0) de_first = n;
                de_last = n;
                de_cnt++;
            end
            if (d_sof) begin
                sof_cnt++;
                sof_n = n; sof_x = int'(d_x); sof_y = int'(d_y);
            end
            if (d_eol) begin
                eol_cnt++;
                eol_n = n; eol_x = int'(d_x);
            end
        end
        checkOutput("def_hsync_low_line0", hs_low_line0, 96);
        checkOutput("def_hsync_low_36lines", hs_low_all, 3456);
        checkOutput("def_vsync_low", vs_low, 1600);
        checkOutput("def_de_first", de_first, 28145);
        checkOutput("def_de_last", de_last, 28784);
        checkOutput("def_de_count", de_cnt, 640);
        checkOutput("def_sof_count", sof_cnt, 1);
        checkOutput("def_sof_cycle", sof_n, 28145);
        checkOutput("def_sof_x", sof_x, 0);
        checkOutput("def_sof_y", sof_y, 0);
        checkOutput("def_eol_count", eol_cnt, 1);
        checkOutput("def_eol_cycle", eol_n, 28784);
        checkOutput("def_eol_x", eol_x, 639);
        checkOutput("def_frame_cnt", 32'(d_frame_cnt), 32'd0);

        // Small timing: restart from reset and run past five frames.
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkSmall(0);
        p = 0;
        for (int i = 0; i < 700; i++) begin
            applyStimulus(1'b0, 1'b1);
            p++;
            checkSmall(p);
        end

        // Stall mid-line at x=3.
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            applyStimulus(1'b0, 1'b1);
            p++;
            checkSmall(p);
            if (s_de && s_x == 8'd3) found = 1;
        end
        checkOutput("find_x3", found, 1);
        hold_x = s_x;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkSmall(p);
            checkOutput("stall_x_frozen", 32'(s_x), 32'(hold_x));
        end
        applyStimulus(1'b0, 1'b1);
        p++;
        checkSmall(p);
        checkOutput("resume_x", 32'(s_x), 32'd4);

        // Enabled cycles between consecutive eol pulses.
        k = -1;
        len = -1;
        for (int i = 0; i < 100 && len < 0; i++) begin
            applyStimulus(1'b0, 1'b1);
            p++;
            checkSmall(p);
            if (k >= 0) k++;
            if (s_eol) begin
                if (k > 0) len = k;
                else k = 0;
            end
        end
        checkOutput("line_len", len, 16);

        // Reset mid-frame at y=2, x=5.
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            applyStimulus(1'b0, 1'b1);
            p++;
            checkSmall(p);
            if (s_de && s_x == 8'd5 && s_y == 8'd2) found = 1;
        end
        checkOutput("find_x5_y2", found, 1);
        applyStimulus(1'b1, 1'b1);
        p = 0;
        checkSmall(p);
        sof_after = -1;
        for (int i = 1; i <= 200 && sof_after < 0; i++) begin
            applyStimulus(1'b0, 1'b1);
            p++;
            checkSmall(p);
            if (s_sof) sof_after = i;
        end
        checkOutput("sof_after_reset", sof_after, 55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
